gf_inv_8_seq: RTL and testbench

//  Multi-cycle GF(2^8) inverter over GF(2^4), normal basis, Canright decomposition.

---
 rtl/gf_inv_8_seq_pkg.sv | 37 +++
 rtl/gf_inv_4.sv | 25 ++
 rtl/gf_muls_4.sv | 25 ++
 rtl/gf_muls_prep_4.sv | 13 +
 rtl/gf_sq_scl_4.sv | 9 +
 rtl/gf_inv_8_seq.sv | 132 +++++++++++++
 tb/tb_gf_inv_8_seq.sv | 204 ++++++++++++++++++++
 7 files changed

// File: rtl/gf_inv_8_seq_pkg.sv
// Shared types and GF(2^2) primitives for the sequential Canright GF(2^8) inverter.
// GF(2^2) elements use the normal basis [W^2, W]; the shared-factor inputs are the pair's bit sums.
package gf_inv_8_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_THETA = 3'd1,
        ST_INV   = 3'd2,
        ST_MULH  = 3'd3,
        ST_MULL  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [1:0] gf_mul2(input logic [1:0] x, input logic xs,
                                           input logic [1:0] y, input logic ys);
        logic t;
        t = xs & ys;
        return {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};
    endfunction

    // Product already scaled by N = W^2.
    function automatic logic [1:0] gf_mul2_scl_n(input logic [1:0] x, input logic xs,
                                                 input logic [1:0] y, input logic ys);
        logic t;
        t = x[0] & y[0];
        return {(xs & ys) ^ t, (x[1] & y[1]) ^ t};
    endfunction

    function automatic logic [1:0] gf_sq2(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf_scl_w2(input logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

endpackage

// File: rtl/gf_inv_4.sv
// GF(2^4) inverse over GF(2^2), normal basis; 0 maps to 0.
module gf_inv_4
    import gf_inv_8_seq_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic [1:0] d;
    logic       sa;
    logic       sb;
    logic       sd;

    assign a  = x_i[3:2];
    assign b  = x_i[1:0];
    assign sa = ^a;
    assign sb = ^b;
    // c = a*b ^ N*(a^b)^2, folded into gate form
    assign c  = {(a[1] | b[1]) ^ (sa & sb), (sa | sb) ^ (a[0] & b[0])};
    assign d  = gf_sq2(c);
    assign sd = ^d;
    assign y_o = {gf_mul2(d, sd, b, sb), gf_mul2(d, sd, a, sa)};
endmodule

// File: rtl/gf_muls_4.sv
// GF(2^4) multiplier over GF(2^2), normal basis, with externally supplied shared factors.
module gf_muls_4
    import gf_inv_8_seq_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [1:0] xs_i,
    input  logic       xl_i,
    input  logic       xh_i,
    input  logic       xx_i,
    input  logic [3:0] y_i,
    input  logic [1:0] ys_i,
    input  logic       yl_i,
    input  logic       yh_i,
    input  logic       yy_i,
    output logic [3:0] q_o
);
    logic [1:0] ph;
    logic [1:0] pl;
    logic [1:0] ps;

    assign ph  = gf_mul2(x_i[3:2], xh_i, y_i[3:2], yh_i);
    assign pl  = gf_mul2(x_i[1:0], xl_i, y_i[1:0], yl_i);
    assign ps  = gf_mul2_scl_n(xs_i, xx_i, ys_i, yy_i);
    assign q_o = {ph ^ ps, pl ^ ps};
endmodule

// File: rtl/gf_muls_prep_4.sv
// Shared-factor operand prep for one GF(2^4) multiplier input: X -> {a, Xh, Xl, aa}.
module gf_muls_prep_4 (
    input  logic [3:0] x_i,
    output logic [1:0] s_o,
    output logic       h_o,
    output logic       l_o,
    output logic       ss_o
);
    assign s_o  = x_i[3:2] ^ x_i[1:0];
    assign h_o  = ^x_i[3:2];
    assign l_o  = ^x_i[1:0];
    assign ss_o = ^s_o;
endmodule

// File: rtl/gf_sq_scl_4.sv
// GF(2^4) square-and-scale by nu, normal basis [alpha^8, alpha^2].
module gf_sq_scl_4
    import gf_inv_8_seq_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] q_o
);
    assign q_o = {gf_sq2(x_i[3:2] ^ x_i[1:0]), gf_scl_w2(gf_sq2(x_i[1:0]))};
endmodule

// File: rtl/gf_inv_8_seq.sv
// Multi-cycle GF(2^8) inverter (Canright, normal basis) reusing one GF(2^4) multiplier for all three products.
// Result 3+REG_INV cycles after accept, one per 5+REG_INV cycles; out_data held until out_ready.
module gf_inv_8_seq
    import gf_inv_8_seq_pkg::*;
#(
    parameter int unsigned REG_INV = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o
);
    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [3:0] d_q, d_d;
    logic [3:0] theta_q, theta_d;
    logic [7:0] out_q, out_d;
    logic       out_vld_q, out_vld_d;

    logic [3:0] op_x, op_y;
    logic [1:0] x_s, y_s;
    logic       x_h, x_l, x_ss;
    logic       y_h, y_l, y_ss;
    logic [3:0] prod;
    logic [3:0] sq_scl;
    logic [3:0] theta;
    logic [3:0] inv_in;
    logic [3:0] inv_out;

    // Operands depend on state only; idle states park the multiplier at zero.
    always_comb begin
        op_x = '0;
        op_y = '0;
        case (state_q)
            ST_THETA: begin op_x = a_q[7:4]; op_y = a_q[3:0]; end
            ST_MULH:  begin op_x = d_q;      op_y = a_q[3:0]; end
            ST_MULL:  begin op_x = d_q;      op_y = a_q[7:4]; end
            default:  ;
        endcase
    end

    gf_muls_prep_4 u_prep_x (.x_i(op_x), .s_o(x_s), .h_o(x_h), .l_o(x_l), .ss_o(x_ss));
    gf_muls_prep_4 u_prep_y (.x_i(op_y), .s_o(y_s), .h_o(y_h), .l_o(y_l), .ss_o(y_ss));

    gf_muls_4 u_mul (
        .x_i (op_x), .xs_i(x_s), .xl_i(x_l), .xh_i(x_h), .xx_i(x_ss),
        .y_i (op_y), .ys_i(y_s), .yl_i(y_l), .yh_i(y_h), .yy_i(y_ss),
        .q_o (prod)
    );

    gf_sq_scl_4 u_sq_scl (.x_i(a_q[7:4] ^ a_q[3:0]), .q_o(sq_scl));

    assign theta  = sq_scl ^ prod;
    assign inv_in = (REG_INV != 0) ? theta_q : theta;

    gf_inv_4 u_inv (.x_i(inv_in), .y_o(inv_out));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        theta_d   = theta_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_data_i;
                    state_d = ST_THETA;
                end
            end
            ST_THETA: begin
                if (REG_INV != 0) begin
                    theta_d = theta;
                    state_d = ST_INV;
                end else begin
                    d_d     = inv_out;
                    state_d = ST_MULH;
                end
            end
            ST_INV: begin
                d_d     = inv_out;
                state_d = ST_MULH;
            end
            ST_MULH: begin
                out_d[7:4] = prod;
                state_d    = ST_MULL;
            end
            ST_MULL: begin
                out_d[3:0] = prod;
                out_vld_d  = 1'b1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                out_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            theta_q   <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            theta_q   <= theta_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_q;
endmodule

// File: tb/tb_gf_inv_8_seq.sv
// Bench for gf_inv_8_seq: reference inverse found by exhaustive search over an independent tower-field multiply.
module tb_gf_inv_8_seq;
    localparam int REG_INV = 0;
    localparam int LAT     = 3 + REG_INV;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] inv_tab [256];
    logic [7:0] exp_q [$];
    logic [7:0] src_q [$];

    logic [7:0] got, got2, junk;
    int         seen;

    always #5 clk = ~clk;

    gf_inv_8_seq #(.REG_INV(REG_INV)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
    );

    // GF(4), basis [W^2, W], W^2+W+1=0: W*W=W^2, W^2*W^2=W, W*W^2=1=W^2+W.
    function automatic logic [1:0] m2(input logic [1:0] a, input logic [1:0] b);
        logic x;
        x = (a[1] & b[0]) ^ (a[0] & b[1]);
        return {(a[0] & b[0]) ^ x, (a[1] & b[1]) ^ x};
    endfunction

    // GF(16) over GF(4), Z^2+Z+N with N=W^2.
    function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] s;
        s = m2(2'b10, m2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {m2(a[3:2], b[3:2]) ^ s, m2(a[1:0], b[1:0]) ^ s};
    endfunction

    // GF(256) over GF(16), Y^2+Y+nu with nu = W*Z.
    function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] s;
        s = m4(4'b0001, m4(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]));
        return {m4(a[7:4], b[7:4]) ^ s, m4(a[3:0], b[3:0]) ^ s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] x);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        exp_q.push_back(inv_tab[x]);
        src_q.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic recv(input string tag, output logic [7:0] res);
        int n;
        logic [7:0] e, s;
        wait_vld(n);
        chk({tag, "_latency"}, n, LAT);
        res = out_data;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        s = (src_q.size() > 0) ? src_q.pop_front() : 8'h00;
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, e});
        if (s != 8'h00) chk({tag, "_prod"}, {24'd0, m8(s, out_data)}, 32'hFF);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            inv_tab[x] = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m8(x[7:0], y[7:0]) == 8'hFF) inv_tab[x] = y[7:0];
        end

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);

        send(8'hFF); recv("ident", got);
        chk("ident_val", {24'd0, got}, 32'hFF);
        send(8'h00); recv("zero", got);
        chk("zero_val", {24'd0, got}, 32'h00);

        for (int x = 0; x < 256; x++) begin
            send(x[7:0]);
            recv("exh", got);
        end

        // backpressure, with a competing in_valid that must be ignored
        send(8'h53);
        wait_vld(seen);
        chk("bp_latency", seen, LAT);
        in_valid = 1'b1; in_data = 8'h11;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_data",  {24'd0, out_data}, {24'd0, inv_tab[8'h53]});
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0; in_data = 8'h00;
        junk = exp_q.pop_front(); junk = src_q.pop_front();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_vld_clr",  {31'd0, out_valid}, 32'd0);
        chk("bp_rdy_next", {31'd0, in_ready},  32'd1);
        send(8'h11); recv("bp_next", got);

        // reset held 2 cycles while in THETA
        send(8'hA7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        junk = exp_q.pop_back(); junk = src_q.pop_back();
        chk("t1_in_ready",  {31'd0, in_ready},  32'd1);
        chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_out_data",  {24'd0, out_data},  32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("t1_no_stale", seen, 0);

        // reset pulsed one cycle later, inside MULH
        send(8'h53);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        junk = exp_q.pop_back(); junk = src_q.pop_back();
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_in_ready",  {31'd0, in_ready},  32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("t6_no_stale", seen, 0);
        send(8'hFF); recv("t6_ff", got);
        chk("t6_ff_val", {24'd0, got}, 32'hFF);
        chk("t6_sb_empty", exp_q.size(), 0);

        foreach (inv_tab[k]) begin
            if (k == 8'h02 || k == 8'h53 || k == 8'hC3 || k == 8'h8E) begin
                send(k[7:0]);  recv("ii_fwd", got);
                send(got);     recv("ii_back", got2);
                chk("inv_inv", {24'd0, got2}, k);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
